// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram controller for the 192x48 microcode ROM.
// Holds the micro-PC, drives the ROM address, decodes the sequencing field of
// the fetched microword and issues its control field to the datapath.
//
// Microword: [47:45] seq_op, [44:42] cond_sel (7 = always), [41:34] target,
//            [33:0] control.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        synchronous reset, active low
//   start_i       begin a microprogram at START_ADDR (sampled only in idle)
//   opcode_i      instruction opcode, used by DISPATCH
//   cond_in_i     status/condition flags
//   stall_i       datapath hold, freezes the sequencer for the cycle
//   rom_addr_o    ROM address, equals the micro-PC
//   rom_data_i    combinational ROM word for rom_addr_o
//   ctrl_out_o    control field when ctrl_valid_o, else 0
//   ctrl_valid_o  running and not stalled
//   busy_o        running
//   done_o        one-cycle pulse after an END word executes
//   fault_o       sticky error flag, cleared only by reset
module micro_sequencer #(
    parameter int unsigned ROM_DEPTH     = 192,
    parameter int unsigned START_ADDR    = 0,
    parameter int unsigned DISPATCH_BASE = 64,
    parameter int unsigned STACK_DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [7:0]  opcode_i,
    input  logic [6:0]  cond_in_i,
    input  logic        stall_i,
    output logic [7:0]  rom_addr_o,
    input  logic [47:0] rom_data_i,
    output logic [33:0] ctrl_out_o,
    output logic        ctrl_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        fault_o
);

    localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFault = 2'd2;

    localparam logic [2:0] OpNext     = 3'd0;
    localparam logic [2:0] OpJump     = 3'd1;
    localparam logic [2:0] OpJcond    = 3'd2;
    localparam logic [2:0] OpCall     = 3'd3;
    localparam logic [2:0] OpRet      = 3'd4;
    localparam logic [2:0] OpDispatch = 3'd5;
    localparam logic [2:0] OpEnd      = 3'd6;

    localparam logic [7:0] StartPc = 8'(START_ADDR);

    logic [1:0]     state_q, state_d;
    logic [7:0]     upc_q, upc_d;
    logic [SpW-1:0] sp_q, sp_d;
    logic           done_q, done_d;
    logic           fault_q, fault_d;
    logic [7:0]     stack_q [STACK_DEPTH];

    logic [2:0]     seq_op;
    logic [2:0]     cond_sel;
    logic [7:0]     target;
    logic [7:0]     cond_vec;
    logic           cond_true;
    logic [8:0]     upc_inc;
    logic [SpW-1:0] sp_top;
    logic [7:0]     stack_top;
    logic [7:0]     dispatch_addr;
    logic [8:0]     nxt;
    logic           take;
    logic           err;
    logic           push;
    logic           unused_opcode;

    assign seq_op   = rom_data_i[47:45];
    assign cond_sel = rom_data_i[44:42];
    assign target   = rom_data_i[41:34];

    // Slot 7 is the constant-true condition.
    assign cond_vec  = {1'b1, cond_in_i};
    assign cond_true = cond_vec[cond_sel];

    // Kept 9 bits wide so stepping past the last ROM word is detectable.
    assign upc_inc   = {1'b0, upc_q} + 9'd1;
    assign sp_top    = sp_q - 1'b1;
    assign stack_top = stack_q[sp_top[IdxW-1:0]];

    // Dispatch sum wraps at 8 bits; only opcode[5:0] selects the entry.
    assign dispatch_addr = 8'(DISPATCH_BASE) + {2'b00, opcode_i[5:0]};
    assign unused_opcode = ^opcode_i[7:6];

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        sp_d    = sp_q;
        done_d  = 1'b0;
        fault_d = fault_q;
        nxt     = {1'b0, upc_q};
        take    = 1'b0;
        err     = 1'b0;
        push    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    upc_d   = StartPc;
                end
            end
            StRun: begin
                if (!stall_i) begin
                    take = 1'b1;
                    case (seq_op)
                        OpNext:  nxt = upc_inc;
                        OpJump:  nxt = {1'b0, target};
                        OpJcond: nxt = cond_true ? {1'b0, target} : upc_inc;
                        OpCall: begin
                            if (sp_q == SpW'(STACK_DEPTH)) begin
                                err = 1'b1;
                            end else begin
                                push = 1'b1;
                                sp_d = sp_q + 1'b1;
                                nxt  = {1'b0, target};
                            end
                        end
                        OpRet: begin
                            if (sp_q == '0) begin
                                err = 1'b1;
                            end else begin
                                sp_d = sp_top;
                                nxt  = {1'b0, stack_top};
                            end
                        end
                        OpDispatch: nxt = {1'b0, dispatch_addr};
                        OpEnd: begin
                            take    = 1'b0;
                            state_d = StIdle;
                            upc_d   = StartPc;
                            done_d  = 1'b1;
                        end
                        default: nxt = cond_true ? upc_inc : {1'b0, upc_q};  // WAIT
                    endcase

                    if (take && (nxt >= 9'(ROM_DEPTH))) begin
                        err = 1'b1;
                    end

                    // A faulting word leaves upc and stack untouched so the
                    // failing address stays visible on rom_addr_o.
                    if (err) begin
                        state_d = StFault;
                        fault_d = 1'b1;
                        upc_d   = upc_q;
                        sp_d    = sp_q;
                        push    = 1'b0;
                    end else if (take) begin
                        upc_d = nxt[7:0];
                    end
                end
            end
            StFault: begin
                fault_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            upc_q   <= StartPc;
            sp_q    <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            sp_q    <= sp_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    // Return stack storage needs no reset; only sp_q defines occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            stack_q[sp_q[IdxW-1:0]] <= upc_inc[7:0];
        end
    end

    assign rom_addr_o   = upc_q;
    assign busy_o       = (state_q == StRun);
    assign ctrl_valid_o = busy_o & ~stall_i;
    assign ctrl_out_o   = ctrl_valid_o ? rom_data_i[33:0] : '0;
    assign done_o       = done_q;
    assign fault_o      = fault_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: scoreboard bench for micro_sequencer. Directed programs
// are loaded into a behavioural ROM; the expected address/control sequence is
// queued up front and a negedge monitor pops and compares on every valid word.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  opcode;
    logic [6:0]  cond_in;
    logic        stall;
    logic [7:0]  rom_addr;
    logic [47:0] rom_data;
    logic [33:0] ctrl_out;
    logic        ctrl_valid;
    logic        busy;
    logic        done;
    logic        fault;

    logic [47:0] rom [256];

    typedef struct packed {
        logic [7:0]  addr;
        logic [33:0] ctl;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, JC = 3'd2, CALL = 3'd3;
    localparam logic [2:0] RET = 3'd4, DSP = 3'd5, ENDW = 3'd6, WAITW = 3'd7;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    micro_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .opcode_i     (opcode),
        .cond_in_i    (cond_in),
        .stall_i      (stall),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .ctrl_out_o   (ctrl_out),
        .ctrl_valid_o (ctrl_valid),
        .busy_o       (busy),
        .done_o       (done),
        .fault_o      (fault)
    );

    // Control field of every word is a per-address tag so ctrl_out is traceable.
    function automatic logic [33:0] tag(input int a);
        return 34'h2_5A00_0000 | 34'(a);
    endfunction

    function automatic logic [47:0] mw(input logic [2:0] op, input logic [2:0] cs,
                                       input logic [7:0] tgt, input int a);
        return {op, cs, tgt, tag(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input int a [$]);
        foreach (a[i]) exp_q.push_back({8'(a[i]), tag(a[i])});
    endtask

    task automatic clr_rom;
        for (int i = 0; i < 256; i++) rom[i] = mw(NXT, 3'd0, 8'd0, i);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        chk("rst_addr", rom_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", {ctrl_valid, 30'd0, ctrl_out}, 0);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Bounded wait for done (want_fault=0) or fault (want_fault=1).
    task automatic wait_for(input bit want_fault, input string name);
        int n = 0;
        while (!(want_fault ? fault : done) && n < 40) begin
            tick;
            n++;
        end
        chk(name, want_fault ? fault : done, 1);
        chk({name, "_q_empty"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every valid control word must match the next queued entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ctrl_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", rom_addr, 8'hFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_addr", rom_addr, e.addr);
                    chk("mon_ctrl", ctrl_out, e.ctl);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = 8'h00; cond_in = 7'h00; stall = 1'b0;
        clr_rom();
        tick;
        do_reset();

        // Straight line, then restart in the same cycle done is high.
        rom[3] = mw(ENDW, 3'd0, 8'd0, 3);
        expect_seq('{0, 1, 2, 3});
        pulse_start();
        wait_for(1'b0, "line_done");
        chk("line_busy", busy, 0);
        chk("line_addr", rom_addr, 0);
        expect_seq('{0, 1, 2, 3});
        pulse_start();
        chk("restart_busy", busy, 1);
        chk("done_pulse", done, 0);
        wait_for(1'b0, "restart_done");

        // Conditional branch, taken then not taken.
        clr_rom();
        rom[0]  = mw(JC, 3'd2, 8'd20, 0);
        rom[20] = mw(ENDW, 3'd0, 8'd0, 20);
        rom[1]  = mw(ENDW, 3'd0, 8'd0, 1);
        cond_in = 7'b0000100;
        expect_seq('{0, 20});
        pulse_start();
        wait_for(1'b0, "jc_taken");
        cond_in = 7'b1111011;
        expect_seq('{0, 1});
        pulse_start();
        wait_for(1'b0, "jc_not_taken");

        // Wait on cond_in[5]: four cycles at 20, then 21.
        clr_rom();
        rom[0]  = mw(JMP, 3'd0, 8'd20, 0);
        rom[20] = mw(WAITW, 3'd5, 8'd0, 20);
        rom[21] = mw(ENDW, 3'd0, 8'd0, 21);
        cond_in = 7'b1011111;
        expect_seq('{0, 20, 20, 20, 20, 21});
        pulse_start();
        tick; tick; tick; tick;
        chk("wait_hold", rom_addr, 20);
        cond_in = 7'b0100000;
        wait_for(1'b0, "wait_done");
        cond_in = 7'h00;

        // Dispatch ignores opcode[7:6]: 64 + 5.
        clr_rom();
        rom[0]  = mw(DSP, 3'd0, 8'd0, 0);
        rom[69] = mw(ENDW, 3'd0, 8'd0, 69);
        opcode  = 8'hC5;
        expect_seq('{0, 69});
        pulse_start();
        wait_for(1'b0, "dispatch");

        // Single call/return.
        clr_rom();
        rom[0]   = mw(CALL, 3'd0, 8'd100, 0);
        rom[100] = mw(RET, 3'd0, 8'd0, 100);
        rom[1]   = mw(ENDW, 3'd0, 8'd0, 1);
        expect_seq('{0, 100, 1});
        pulse_start();
        wait_for(1'b0, "call_ret");

        // Four nested calls fill the stack, unwound in LIFO order.
        clr_rom();
        rom[0]  = mw(CALL, 3'd0, 8'd10, 0);
        rom[10] = mw(CALL, 3'd0, 8'd20, 10);
        rom[20] = mw(CALL, 3'd0, 8'd30, 20);
        rom[30] = mw(CALL, 3'd0, 8'd40, 30);
        rom[40] = mw(RET, 3'd0, 8'd0, 40);
        rom[31] = mw(RET, 3'd0, 8'd0, 31);
        rom[21] = mw(RET, 3'd0, 8'd0, 21);
        rom[11] = mw(RET, 3'd0, 8'd0, 11);
        rom[1]  = mw(ENDW, 3'd0, 8'd0, 1);
        expect_seq('{0, 10, 20, 30, 40, 31, 21, 11, 1});
        pulse_start();
        wait_for(1'b0, "nest4");
        chk("nest4_fault", fault, 0);

        // Fifth call overflows.
        rom[40] = mw(CALL, 3'd0, 8'd50, 40);
        expect_seq('{0, 10, 20, 30, 40});
        pulse_start();
        wait_for(1'b1, "overflow");
        chk("ovf_addr", rom_addr, 40);
        chk("ovf_busy", busy, 0);
        chk("ovf_valid", ctrl_valid, 0);
        pulse_start();
        tick;
        chk("fault_start_fault", fault, 1);
        chk("fault_start_busy", busy, 0);
        chk("fault_start_addr", rom_addr, 40);
        do_reset();

        // RET with an empty stack.
        clr_rom();
        rom[0] = mw(RET, 3'd0, 8'd0, 0);
        expect_seq('{0});
        pulse_start();
        wait_for(1'b1, "ret_empty");
        chk("ret_empty_addr", rom_addr, 0);
        do_reset();

        // NEXT at the last word must not wrap.
        clr_rom();
        rom[0]   = mw(JMP, 3'd0, 8'd191, 0);
        rom[191] = mw(NXT, 3'd0, 8'd0, 191);
        expect_seq('{0, 191});
        pulse_start();
        wait_for(1'b1, "next_191");
        chk("next_191_addr", rom_addr, 191);
        do_reset();

        // Jump target beyond the ROM.
        clr_rom();
        rom[0] = mw(JMP, 3'd0, 8'd200, 0);
        expect_seq('{0});
        pulse_start();
        wait_for(1'b1, "jump_oob");
        chk("jump_oob_addr", rom_addr, 0);
        do_reset();

        // Stall for three cycles at address 2.
        clr_rom();
        rom[4] = mw(ENDW, 3'd0, 8'd0, 4);
        expect_seq('{0, 1, 2, 3, 4});
        pulse_start();
        tick; tick;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_addr", rom_addr, 2);
            chk("stall_valid", ctrl_valid, 0);
            chk("stall_ctrl", ctrl_out, 0);
            chk("stall_busy", busy, 1);
            if (i < 2) tick;
        end
        tick;
        chk("stall_release_addr", rom_addr, 2);
        stall = 1'b0;
        wait_for(1'b0, "stall_done");

        // Reset in the middle of a call leaves the stack empty.
        clr_rom();
        rom[0]  = mw(CALL, 3'd0, 8'd10, 0);
        rom[13] = mw(ENDW, 3'd0, 8'd0, 13);
        expect_seq('{0, 10});
        pulse_start();
        tick;
        @(negedge clk);
        #1;
        chk("midrun_q_empty", exp_q.size(), 0);
        do_reset();
        rom[0] = mw(RET, 3'd0, 8'd0, 0);
        expect_seq('{0});
        pulse_start();
        wait_for(1'b1, "sp_cleared");
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
